mac_req_arbiter: RTL
====================

Name: mac_req_arbiter

Overview:
- Parametrised request-queue and arbitration front end for the memory access controller.
- Accepts NCH independent request channels (default 2: ch0 = write/store, ch1 = read/load) and buffers each in its own FIFO.
- Picks one request per cycle using QoS-urgent, starvation-protected, bank-aware round-robin.
- Presents the winner, with decoded bank and load/store flag, through a registered valid/ready slot to the per-bank reorder stages.

Parameters:
- NCH, 2: number of request channels.
- ASIZE, 5: log2 of per-channel FIFO depth (depth 32).
- ADDR_W, 32: request address width.
- REQ_W, 45: packed request width, {addr[31:0], tag[3:0], id[2:0], len[1:0], qos[3:0]}.
- NBANK, 4: number of SDRAM banks (power of 2).
- BANK_LSB, 10: LSB of the bank field in addr; the field spans log2(NBANK) bits.
- QOS_URGENT, 12: a head with qos >= this value is urgent.
- STARVE_LIMIT, 15: eligible-but-ungranted cycles before a channel is forced.
- LOAD_MASK, 'b10: bit c = 1 means channel c is a load (read) channel.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- iArb_Valid  in  NCH  per-channel request valid.
- iArb_Req  in  NCH*REQ_W  per-channel packed request; channel c occupies [c*REQ_W +: REQ_W].
- oArb_Ready  out  NCH  per-channel ready, = ~full.
- iBank_Full  in  NBANK  per-bank reorder-stage full.
- oArb_Valid  out  1  output slot valid.
- oArb_Req  out  REQ_W  granted request.
- oArb_Bank  out  log2(NBANK)  bank of the granted request.
- oArb_Chan  out  log2(NCH) (min 1)  granted channel index.
- oArb_LoS  out  1  1 = load, 0 = store (LOAD_MASK[chan]).
- iArb_Ready  in  1  consumer accepts the output slot.

Behaviour:
- Reset (synchronous, active-high; dominates all other events):
  - All FIFOs empty; oArb_Ready all 1.
  - oArb_Valid = 0; oArb_Req, oArb_Bank, oArb_Chan and oArb_LoS = 0.
  - RR pointer = 0; all age counters = 0.
  - A request asserted in the same cycle as reset is dropped.
- Push: channel c writes when iArb_Valid[c] & oArb_Ready[c].
  - No pass-through when full; data must never be overwritten.
  - Push and pop in the same cycle are allowed when the FIFO is neither empty nor full; count is unchanged.
- Eligibility: channel c is eligible when its FIFO is non-empty and iBank_Full[bank(head_c)] = 0.
- Slot load: the output slot loads when it is empty or (oArb_Valid & iArb_Ready), and at least one channel is eligible.
  - The winner's FIFO pops in the same cycle the slot loads.
- Winner priority:
  1. Lowest-index channel whose age counter = STARVE_LIMIT.
  2. Among eligible urgent heads (qos >= QOS_URGENT), the highest qos; ties go to the first index at or after the RR pointer.
  3. Otherwise, the first eligible channel at or after the RR pointer.
- RR pointer: after a grant it becomes (winner+1) mod NCH; it is unchanged otherwise.
- Age counters: increment (saturating at STARVE_LIMIT) when the channel is eligible and not granted; clear on grant or when the FIFO is empty.
- Head-of-line blocking is per channel only: a bank-blocked head never blocks other channels.
- Output slot: holds stable while oArb_Valid & ~iArb_Ready.
  - oArb_Valid deasserts the cycle after the slot is consumed if nothing was eligible.
- Latency: a request pushed at edge E0 is visible at the FIFO head after E0, and can be registered into the slot at E1. Minimum push-to-oArb_Valid is 2 cycles.
- Throughput: 1 request per cycle with iArb_Ready held high.
- Ordering: order within a channel is always preserved. No ordering is guaranteed across channels.
- Bank decode: bank = addr[BANK_LSB +: log2(NBANK)], taken from REQ_W[REQ_W-1 -: ADDR_W].

Decomposition:
- Package mac_pkg holds:
  - Command encodings: NOP, READA, WRITEA, REFRESH, PRECHARGE, LOAD_MODE, LOAD_REG1, LOAD_REG2.
  - REQ field widths and offsets: addr, tag, id, len, qos.
  - Default BANK_LSB, ROW_W = 11, COL_W = 8, BANK_W = 2.
- One sub-module, mac_sync_fifo (params DSIZE, ASIZE; ports wr, rd, wdata, rdata, full, empty), instantiated NCH times.
- The arbiter, age counters and output slot live in the top module.

Test Plan:
- Reset mid-traffic: fill ch0 with 3 requests, assert reset 1 cycle -> next cycle oArb_Valid = 0, oArb_Ready = 'b11, no stale request ever emitted.
- Alternation: ch0 and ch1 each hold 4 requests, qos = 0, banks all free, iArb_Ready = 1 -> grants ch0,ch1,ch0,ch1,... back to back; oArb_LoS = 0,1,0,1; first valid 2 cycles after first push.
- Bank blocking: ch0 head bank 2, iBank_Full = 'b0100, ch1 holds bank-0 requests -> only ch1 granted; after iBank_Full clears, ch0 head granted next cycle.
- QoS urgent: ch0 head qos = 3, ch1 head qos = 13, pointer at ch0 -> ch1 granted first.
- Starvation: ch1 streams urgent qos = 15 requests while ch0 holds qos = 0 -> ch0 is granted at the latest on cycle STARVE_LIMIT+1 after becoming eligible.
- Full/backpressure: iArb_Ready = 0, push 33 requests on ch0 -> oArb_Ready[0] drops once 32 are stored plus 1 in the slot. Then release -> all 33 emerge in push order with no loss or duplication.

Source files
------------

// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the memory access controller front end.
//   - SDRAM command encodings
//   - Packed request layout {addr, tag, id, len, qos}: field widths and LSBs
//   - Default SDRAM geometry (bank field position, row/column/bank widths)
// No ports; imported by mac_sync_fifo and mac_req_arbiter.
// -----------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic [2:0] {
        NOP       = 3'd0,
        READA     = 3'd1,
        WRITEA    = 3'd2,
        REFRESH   = 3'd3,
        PRECHARGE = 3'd4,
        LOAD_MODE = 3'd5,
        LOAD_REG1 = 3'd6,
        LOAD_REG2 = 3'd7
    } macCmd_t;

    // Request fields, listed from LSB upward.
    localparam int REQ_QOS_W    = 4;
    localparam int REQ_QOS_LSB  = 0;
    localparam int REQ_LEN_W    = 2;
    localparam int REQ_LEN_LSB  = REQ_QOS_LSB + REQ_QOS_W;   // 4
    localparam int REQ_ID_W     = 3;
    localparam int REQ_ID_LSB   = REQ_LEN_LSB + REQ_LEN_W;   // 6
    localparam int REQ_TAG_W    = 4;
    localparam int REQ_TAG_LSB  = REQ_ID_LSB + REQ_ID_W;     // 9
    localparam int REQ_ADDR_W   = 32;
    localparam int REQ_ADDR_LSB = REQ_TAG_LSB + REQ_TAG_W;   // 13
    localparam int REQ_WIDTH    = REQ_ADDR_LSB + REQ_ADDR_W; // 45

    // SDRAM geometry defaults.
    localparam int DEF_BANK_LSB = 10;
    localparam int ROW_W        = 11;
    localparam int COL_W        = 8;
    localparam int BANK_W       = 2;

endpackage

// File: rtl/mac_sync_fifo.sv
// -----------------------------------------------------------------------------
// mac_sync_fifo
// Single-clock FIFO of depth 2**ASIZE with a combinational (show-ahead) head:
// a word written at edge E is visible on rdata right after E.
// Ports:
//   clk, reset     clock, synchronous active-high reset (empties the FIFO)
//   wr, wdata      write request / data; ignored while full (no overwrite)
//   rd             pop the head; ignored while empty
//   rdata          current head word
//   full, empty    status flags
// -----------------------------------------------------------------------------
module mac_sync_fifo
    import mac_pkg::*;
#(
    parameter int DSIZE = REQ_WIDTH,
    parameter int ASIZE = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [DSIZE-1:0] wdata,
    output logic [DSIZE-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when indices match.
    logic [ASIZE:0]   wPtr;
    logic [ASIZE:0]   rPtr;
    logic             wrEn;
    logic             rdEn;

    assign wrEn  = wr & ~full;
    assign rdEn  = rd & ~empty;
    assign empty = (wPtr == rPtr);
    assign full  = (wPtr[ASIZE] != rPtr[ASIZE]) &&
                   (wPtr[ASIZE-1:0] == rPtr[ASIZE-1:0]);
    assign rdata = mem[rPtr[ASIZE-1:0]];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wPtr[ASIZE-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wPtr <= '0;
            rPtr <= '0;
        end else begin
            if (wrEn) begin
                wPtr <= wPtr + 1'b1;
            end
            if (rdEn) begin
                rPtr <= rPtr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_req_arbiter.sv
// -----------------------------------------------------------------------------
// mac_req_arbiter
// Request queue and arbitration front end of the memory access controller.
// Each of NCH channels is buffered in its own FIFO; one head per cycle is
// chosen (starvation override > QoS urgent > round robin), skipping heads
// whose target bank is full, and registered into a single output slot.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   iArb_Valid    per-channel request valid
//   iArb_Req      per-channel packed request, channel c at [c*REQ_W +: REQ_W]
//   oArb_Ready    per-channel ready (= FIFO not full)
//   iBank_Full    per-bank reorder stage full
//   oArb_Valid    output slot valid
//   oArb_Req      granted request
//   oArb_Bank     bank decoded from the granted request address
//   oArb_Chan     granted channel index
//   oArb_LoS      1 = load, 0 = store
//   iArb_Ready    consumer accepts the output slot
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. On the input side ready does not depend on valid. On the output side
// the slot holds oArb_Req/Bank/Chan/LoS stable while oArb_Valid & ~iArb_Ready,
// and reloads in the same edge it is consumed when a channel is eligible.
// -----------------------------------------------------------------------------
module mac_req_arbiter
    import mac_pkg::*;
#(
    parameter int              NCH          = 2,
    parameter int              ASIZE        = 5,
    parameter int              ADDR_W       = REQ_ADDR_W,
    parameter int              REQ_W        = REQ_WIDTH,
    parameter int              NBANK        = 4,
    parameter int              BANK_LSB     = DEF_BANK_LSB,
    parameter int              QOS_URGENT   = 12,
    parameter int              STARVE_LIMIT = 15,
    parameter logic [NCH-1:0]  LOAD_MASK    = 2'b10,
    localparam int             BW           = (NBANK > 1) ? $clog2(NBANK) : 1,
    localparam int             CW           = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       iArb_Valid,
    input  logic [NCH*REQ_W-1:0] iArb_Req,
    output logic [NCH-1:0]       oArb_Ready,
    input  logic [NBANK-1:0]     iBank_Full,
    output logic                 oArb_Valid,
    output logic [REQ_W-1:0]     oArb_Req,
    output logic [BW-1:0]        oArb_Bank,
    output logic [CW-1:0]        oArb_Chan,
    output logic                 oArb_LoS,
    input  logic                 iArb_Ready
);

    localparam int                   AGEW     = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGEW-1:0]      AGE_MAX  = AGEW'(STARVE_LIMIT);
    localparam logic [REQ_QOS_W-1:0] QOS_URG  = REQ_QOS_W'(QOS_URGENT);
    // Bit position of the bank field inside the packed request.
    localparam int                   BANK_POS = REQ_W - ADDR_W + BANK_LSB;

    logic [REQ_W-1:0]     headReq  [NCH];
    logic [BW-1:0]        headBank [NCH];
    logic [REQ_QOS_W-1:0] headQos  [NCH];
    logic [AGEW-1:0]      age      [NCH];

    logic [NCH-1:0] fifoEmpty;
    logic [NCH-1:0] fifoFull;
    logic [NCH-1:0] pushVec;
    logic [NCH-1:0] popVec;
    logic [NCH-1:0] eligible;

    logic [CW-1:0]  rrPtr;
    logic [CW-1:0]  winner;
    logic           slotLoad;

    logic                 starveHit;
    logic [CW-1:0]        starveIdx;
    logic                 urgentHit;
    logic [CW-1:0]        urgentIdx;
    logic [REQ_QOS_W-1:0] bestQos;
    logic                 rrHit;
    logic [CW-1:0]        rrIdx;

    assign oArb_Ready = ~fifoFull;

    // ---------------- per-channel queues ----------------
    for (genvar c = 0; c < NCH; c++) begin : g_chan
        assign pushVec[c] = iArb_Valid[c] & ~fifoFull[c];

        mac_sync_fifo #(
            .DSIZE (REQ_W),
            .ASIZE (ASIZE)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .wr    (pushVec[c]),
            .rd    (popVec[c]),
            .wdata (iArb_Req[c*REQ_W +: REQ_W]),
            .rdata (headReq[c]),
            .full  (fifoFull[c]),
            .empty (fifoEmpty[c])
        );

        assign headBank[c] = headReq[c][BANK_POS +: BW];
        assign headQos[c]  = headReq[c][REQ_QOS_LSB +: REQ_QOS_W];
        // A blocked head stalls only its own channel.
        assign eligible[c] = ~fifoEmpty[c] & ~iBank_Full[headBank[c]];
    end

    // ---------------- winner selection ----------------
    always_comb begin
        int idx;
        idx       = 0;
        starveHit = 1'b0;
        starveIdx = '0;
        urgentHit = 1'b0;
        urgentIdx = '0;
        bestQos   = '0;
        rrHit     = 1'b0;
        rrIdx     = '0;

        // Starvation override: lowest index first. Eligibility is also
        // required so a saturated counter never forces a bank-blocked head.
        for (int c = 0; c < NCH; c++) begin
            if (!starveHit && eligible[c] && (age[c] == AGE_MAX)) begin
                starveHit = 1'b1;
                starveIdx = CW'(c);
            end
        end

        // Scan from the RR pointer; a strict '>' keeps the first-found
        // channel on a qos tie, which is the RR tie-break.
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(rrPtr) + k) % NCH;
            if (eligible[idx] && (headQos[idx] >= QOS_URG) &&
                (!urgentHit || (headQos[idx] > bestQos))) begin
                urgentHit = 1'b1;
                urgentIdx = CW'(idx);
                bestQos   = headQos[idx];
            end
            if (!rrHit && eligible[idx]) begin
                rrHit = 1'b1;
                rrIdx = CW'(idx);
            end
        end
    end

    assign winner   = starveHit ? starveIdx : (urgentHit ? urgentIdx : rrIdx);
    assign slotLoad = (~oArb_Valid | iArb_Ready) & (|eligible);

    always_comb begin
        popVec = '0;
        for (int c = 0; c < NCH; c++) begin
            popVec[c] = slotLoad && (winner == CW'(c));
        end
    end

    // ---------------- output slot and RR pointer ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            oArb_Valid <= 1'b0;
            oArb_Req   <= '0;
            oArb_Bank  <= '0;
            oArb_Chan  <= '0;
            oArb_LoS   <= 1'b0;
            rrPtr      <= '0;
        end else if (slotLoad) begin
            oArb_Valid <= 1'b1;
            oArb_Req   <= headReq[winner];
            oArb_Bank  <= headBank[winner];
            oArb_Chan  <= winner;
            oArb_LoS   <= LOAD_MASK[winner];
            rrPtr      <= (winner == CW'(NCH - 1)) ? '0 : winner + 1'b1;
        end else if (iArb_Ready) begin
            // Slot consumed (or already empty) with nothing to replace it.
            oArb_Valid <= 1'b0;
        end
    end

    // ---------------- age counters ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                age[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (fifoEmpty[c] || popVec[c]) begin
                    age[c] <= '0;
                end else if (eligible[c] && (age[c] != AGE_MAX)) begin
                    age[c] <= age[c] + 1'b1;
                end
            end
        end
    end

endmodule
